// File: rtl/fpu_pkg.sv
// Shared FPU constants, the fp32 field struct and the divider state enum.
// Imported by the add/sub unit, fp32_classify and fp32_div_seq.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int ITERS = MAN_W + 3;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM_RND,
        S_DONE
    } state_e;

endpackage

// File: rtl/fp32_classify.sv
// Combinational operand classifier for one fp32 value.
// Ports: op (in fp32_t); is_zero, is_inf, is_nan, is_sub (out).
module fp32_classify
    import fpu_pkg::*;
(
    input  fp32_t op,
    output logic  is_zero,
    output logic  is_inf,
    output logic  is_nan,
    output logic  is_sub
);

    logic exp_zero;
    logic exp_ones;
    logic man_zero;

    assign exp_zero = (op.exp == '0);
    assign exp_ones = (op.exp == '1);
    assign man_zero = (op.man == '0);

    assign is_zero = exp_zero & man_zero;
    assign is_sub  = exp_zero & ~man_zero;
    assign is_inf  = exp_ones & man_zero;
    assign is_nan  = exp_ones & ~man_zero;

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential fp32 divider, result = a / b, restoring division one bit per cycle.
// Ports: clk, rst_n (sync, low); in_valid/in_ready/a/b; out_valid/out_ready/result + flags.
module fp32_div_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);

    state_e             state_q, state_d;
    fp32_t              a_q, a_d, b_q, b_d;
    logic [24:0]        rem_q, rem_d;
    logic [25:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [31:0]        res_q, res_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic               dbz_q, dbz_d, inv_q, inv_d;

    logic a_zc, a_inf, a_nan, a_sub;
    logic b_zc, b_inf, b_nan, b_sub;

    fp32_classify u_cls_a (
        .op      (a_q),
        .is_zero (a_zc),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .is_sub  (a_sub)
    );

    fp32_classify u_cls_b (
        .op      (b_q),
        .is_zero (b_zc),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .is_sub  (b_sub)
    );

    // Subnormals flush to zero
    logic a_zero, b_zero, special, sign;
    assign a_zero  = a_zc | a_sub;
    assign b_zero  = b_zc | b_sub;
    assign special = a_nan | b_nan | a_zero | b_zero | a_inf | b_inf;
    assign sign    = a_q.sign ^ b_q.sign;

    // One restoring step; the first step runs on the UNPACK edge from ma
    logic [23:0] mb;
    logic [24:0] rem_src, rem_sub, rem_nxt;
    logic [25:0] quo_src, quo_nxt;
    logic        q_bit;

    assign mb      = {1'b1, b_q.man};
    assign rem_src = (state_q == S_UNPACK) ? {2'b01, a_q.man} : rem_q;
    assign quo_src = (state_q == S_UNPACK) ? '0 : quo_q;
    assign q_bit   = (rem_src >= {1'b0, mb});
    assign rem_sub = q_bit ? rem_src - {1'b0, mb} : rem_src;
    assign rem_nxt = rem_sub << 1;
    assign quo_nxt = (quo_src << 1) | 26'(q_bit);

    // Normalise (q in (0.5,2)) and round to nearest even
    logic [22:0]       n_frac;
    logic              n_lsb, n_g, n_r, sticky, rnd_up;
    logic [23:0]       n_sum;
    logic signed [9:0] n_exp, f_exp;

    assign sticky = |rem_q;
    assign n_frac = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
    assign n_lsb  = n_frac[0];
    assign n_g    = quo_q[25] ? quo_q[1] : quo_q[0];
    assign n_r    = quo_q[25] & quo_q[0];
    assign n_exp  = quo_q[25] ? exp_q : exp_q - 10'sd1;
    assign rnd_up = n_g & (n_r | sticky | n_lsb);
    // Carry out of the fraction means mantissa rolled to 2.0
    assign n_sum  = {1'b0, n_frac} + {23'd0, rnd_up};
    assign f_exp  = n_exp + $signed({9'd0, n_sum[23]});

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        dbz_d   = dbz_q;
        inv_d   = inv_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (special) begin
                    state_d = S_DONE;
                    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
                        res_d = QNAN;
                        inv_d = 1'b1;
                    end else if (b_zero & ~a_inf) begin
                        res_d = {sign, POS_INF[30:0]};
                        dbz_d = 1'b1;
                    end else if (a_inf) begin
                        res_d = {sign, POS_INF[30:0]};
                    end else begin
                        res_d = {sign, 31'd0};
                    end
                end else begin
                    rem_d   = rem_nxt;
                    quo_d   = quo_nxt;
                    cnt_d   = 5'(ITERS - 2);
                    exp_d   = $signed({2'b00, a_q.exp}) - $signed({2'b00, b_q.exp})
                              + 10'(BIAS);
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == '0) state_d = S_NORM_RND;
            end
            S_NORM_RND: begin
                state_d = S_DONE;
                if (f_exp >= 10'sd255) begin
                    res_d = {sign, POS_INF[30:0]};
                    ovf_d = 1'b1;
                end else if (f_exp <= 10'sd0) begin
                    res_d = {sign, 31'd0};
                    unf_d = 1'b1;
                end else begin
                    res_d = {sign, f_exp[7:0], n_sum[22:0]};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    inv_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dbz_q   <= dbz_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = res_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign div_by_zero = dbz_q;
    assign invalid     = inv_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: directed cases, backpressure, reset abort,
// and random operands against an exact integer-quotient reference model.
module tb_fp32_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        invalid;

    int n_cmp = 0;
    int n_bad = 0;

    fp32_div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {overflow, underflow, div_by_zero, invalid};
    endfunction

    // Reference: returns {latency, flags{ovf,unf,dbz,inv}, result}
    function automatic logic [43:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        int    ex, ey, e, sh;
        logic  s, xz, yz, xi, yi, xn, yn;
        longint num, q, r, mant, low, half, mb;
        logic  up;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        if (xn || yn || (xz && yz) || (xi && yi)) return {8'd2, 4'b0001, 32'h7FC00000};
        if (yz && !xi) return {8'd2, 4'b0010, s, 31'h7F800000};
        if (xi) return {8'd2, 4'b0000, s, 31'h7F800000};
        if (xz || yi) return {8'd2, 4'b0000, s, 31'd0};
        num = longint'({1'b1, x[22:0]}) << 26;
        mb  = longint'({1'b1, y[22:0]});
        q   = num / mb;
        r   = num % mb;
        e   = ex - ey + 127;
        if (q >= (longint'(1) << 26)) sh = 3;
        else begin
            sh = 2;
            e  = e - 1;
        end
        mant = q >> sh;
        low  = q & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        up   = (low > half) || ((low == half) && ((r != 0) || mant[0]));
        mant = mant + longint'(up);
        if (mant == (longint'(1) << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {8'd28, 4'b1000, s, 31'h7F800000};
        if (e <= 0) return {8'd28, 4'b0100, s, 31'd0};
        return {8'd28, 4'b0000, s, e[7:0], mant[22:0]};
    endfunction

    // Waits for out_valid; lat counts edges including the handshake edge
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          output logic [31:0] r, output logic [3:0] fl,
                          output int lat);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        wait_done(lat);
        r  = result;
        fl = flags_now();
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [31:0] ta,
                            input logic [31:0] tb);
        logic [43:0] exp;
        logic [31:0] r;
        logic [3:0]  fl;
        int          lat;
        exp = ref_div(ta, tb);
        run_op(ta, tb, r, fl, lat);
        chk({tag, "_result"}, r, exp[31:0]);
        chk({tag, "_flags"}, {28'd0, fl}, {28'd0, exp[35:32]});
        chk({tag, "_latency"}, lat, {24'd0, exp[43:36]});
    endtask

    initial begin
        logic [31:0] r, hold_r, x, y;
        logic [3:0]  fl, hold_f;
        int          lat, k;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, flags_now()}, 32'd0);

        check_op("six_by_two", 32'h40C00000, 32'h40000000);
        chk("six_by_two_lit", result, 32'h40400000);
        retire();
        check_op("one_third", 32'h3F800000, 32'h40400000);
        chk("one_third_lit", result, 32'h3EAAAAAB);
        retire();
        check_op("div_zero", 32'h3F800000, 32'h00000000);
        chk("div_zero_dbz", {31'd0, div_by_zero}, 32'd1);
        retire();
        check_op("zero_zero", 32'h00000000, 32'h00000000);
        chk("zero_zero_lit", result, 32'h7FC00000);
        retire();
        check_op("ovf", 32'h7F000000, 32'h3E800000);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        retire();
        check_op("unf", 32'h00800000, 32'h40000000);
        chk("unf_flag", {31'd0, underflow}, 32'd1);
        retire();
        check_op("nan_in", 32'h7FC12345, 32'h3F800000);
        retire();
        check_op("inf_inf", 32'hFF800000, 32'h7F800000);
        retire();
        check_op("sub_in", 32'h80001234, 32'h40000000);
        retire();
        check_op("x_inf", 32'hC0000000, 32'h7F800000);
        retire();

        // Backpressure: outputs frozen while out_ready is low
        run_op(32'h40C00000, 32'h40400000, r, fl, lat);
        hold_r = result;
        hold_f = flags_now();
        chk("bp_result0", hold_r, 32'h40000000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_result", result, hold_r);
            chk("bp_flags", {28'd0, flags_now()}, {28'd0, hold_f});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end

        // Retire and offer a new operand in the same cycle
        a         = 32'h40C00000;
        b         = 32'h40000000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("overlap_idle", {31'd0, in_ready}, 32'd1);
        chk("overlap_no_valid", {31'd0, out_valid}, 32'd0);
        chk("overlap_flags_clr", {28'd0, flags_now()}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("overlap_accepted", {31'd0, in_ready}, 32'd0);
        wait_done(lat);
        chk("overlap_result", result, 32'h40400000);
        chk("overlap_latency", lat, 32'd28);
        retire();

        // Reset during DIVIDE aborts the operation
        a        = 32'h3F800000;
        b        = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_never_valid", {31'd0, out_valid}, 32'd0);
        check_op("after_abort", 32'h40C00000, 32'h40000000);
        chk("after_abort_lit", result, 32'h40400000);
        retire();

        // Random operands, biased toward the normal path
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            y = $urandom;
            k = $urandom_range(0, 15);
            if (k < 10) begin
                x[30:23] = 8'($urandom_range(90, 165));
                y[30:23] = 8'($urandom_range(90, 165));
            end else if (k == 10) x[30:23] = 8'd0;
            else if (k == 11) y[30:23] = 8'd0;
            else if (k == 12) y[30:23] = 8'hFF;
            else if (k == 13) x[30:23] = 8'hFF;
            else if (k == 14) begin
                x[30:23] = 8'($urandom_range(240, 254));
                y[30:23] = 8'($urandom_range(100, 130));
            end else begin
                x[30:23] = 8'($urandom_range(1, 20));
                y[30:23] = 8'($urandom_range(120, 150));
            end
            check_op("rand", x, y);
            retire();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
